// File: rtl/wifi_pkg.sv
// Shared types and constants for the Wi-Fi transmit scheduler and its arbiter.
package wifi_pkg;

  localparam int WIFI_DW      = 32;
  localparam int WIFI_TIMEOUT = 1024;
  localparam int WIFI_NUM_REQ = 3;

  // Source-id width; a single requester still needs a one-bit id.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W = src_width(WIFI_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT
  } state_t;

endpackage

// File: rtl/wifi_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after last_gnt wins,
// wrapping to the lowest index.
module rr_arbiter
  import wifi_pkg::*;
#(
  parameter  int NUM_REQ = WIFI_NUM_REQ,
  localparam int SW      = src_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SW-1:0]      last_gnt,
  output logic [SW-1:0]      gnt,
  output logic               any_req
);

  logic          hi_found;
  logic [SW-1:0] hi_gnt;
  logic [SW-1:0] lo_gnt;

  // Scan downward so the lowest qualifying index is the one left standing.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    hi_found = 1'b0;
    hi_gnt   = '0;
    lo_gnt   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_gnt)) begin
          hi_found = 1'b1;
          hi_gnt   = SW'(i);
        end else begin
          lo_gnt = SW'(i);
        end
      end
    end
    gnt = hi_found ? hi_gnt : lo_gnt;
  end

  assign any_req = |req;

endmodule

// File: rtl/wifi_tx_sched.sv
// Packet-atomic round-robin scheduler muxing NUM_REQ word streams onto one
// Wi-Fi transmit port, with stall-timeout abort.
module wifi_tx_sched
  import wifi_pkg::*;
#(
  parameter  int NUM_REQ = WIFI_NUM_REQ,
  parameter  int TIMEOUT = WIFI_TIMEOUT,
  parameter  int DW      = WIFI_DW,
  localparam int SW      = src_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wifi_valid,
  output logic [DW-1:0]         wifi_data,
  output logic                  wifi_last,
  output logic                  wifi_abort,
  output logic [SW-1:0]         wifi_src,
  input  logic                  wifi_ready,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  logic [SW-1:0] gnt;
  logic [SW-1:0] last_gnt;
  logic [SW-1:0] arb_gnt;
  logic          any_req;
  logic [CW-1:0] stall_cnt;

  logic          cur_valid;
  logic          cur_last;
  logic [DW-1:0] cur_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .any_req  (any_req)
  );

  // Select the granted source's stream without variable part-selects.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == SW'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Pass-through in XFER keeps the datapath free of added latency.
  always_comb begin
    wifi_valid = 1'b0;
    wifi_data  = '0;
    wifi_last  = 1'b0;
    wifi_abort = 1'b0;
    req_ready  = '0;
    unique case (state)
      XFER: begin
        wifi_valid = cur_valid;
        wifi_data  = cur_data;
        wifi_last  = cur_last;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (gnt == SW'(i)) && wifi_ready;
        end
      end
      ABORT: begin
        wifi_valid = 1'b1;
        wifi_last  = 1'b1;
        wifi_abort = 1'b1;
      end
      default: ;
    endcase
  end

  assign wifi_src = gnt;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      last_gnt    <= SW'(NUM_REQ - 1);
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (en && any_req) begin
            gnt   <= arb_gnt;
            state <= XFER;
          end
        end
        XFER: begin
          if (cur_valid) begin
            stall_cnt <= '0;
            if (wifi_ready && cur_last) begin
              last_gnt <= gnt;
              state    <= IDLE;
            end
          end else if (stall_cnt == CW'(TIMEOUT - 1)) begin
            stall_cnt <= '0;
            state     <= ABORT;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (wifi_ready) begin
            err_timeout <= 1'b1;
            last_gnt    <= gnt;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wifi_tx_sched.sv
// Self-checking bench: directed scenarios plus a randomized run, all checked
// per cycle against a packet-level model of the scheduling rules.
module tb_wifi_tx_sched;
  import wifi_pkg::*;

  localparam int N  = 3;
  localparam int T  = 8;
  localparam int DW = 32;
  localparam int SW = src_width(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          wifi_valid, wifi_last, wifi_abort, busy, err_timeout;
  logic [DW-1:0] wifi_data;
  logic [SW-1:0] wifi_src;
  logic          wifi_ready = 1'b0;

  always #5 clk = ~clk;

  wifi_tx_sched #(.NUM_REQ(N), .TIMEOUT(T), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wifi_valid(wifi_valid), .wifi_data(wifi_data),
    .wifi_last(wifi_last), .wifi_abort(wifi_abort), .wifi_src(wifi_src),
    .wifi_ready(wifi_ready), .busy(busy), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source word stores: each source replays its queued packets in order.
  logic [31:0] mem_d [N][256];
  logic        mem_l [N][256];
  int head [N];
  int tail [N];
  int gap  [N];

  task automatic push_pkt(input int s, input int len, input logic [31:0] base);
    for (int k = 0; k < len; k++) begin
      mem_d[s][tail[s]] = base + 32'(k);
      mem_l[s][tail[s]] = (k == len - 1);
      tail[s]++;
    end
  endtask

  // Packet-level model of the scheduler.
  typedef enum {M_IDLE, M_PKT, M_ABT} mstate_e;
  mstate_e m_st;
  int  m_src, m_last, m_stall, m_xfer;
  bit  m_err;
  int  cyc = 0;
  int  gnt_hist[$];
  int  gnt_cyc[$];
  int  beats [N];
  int  abort_cnt, abort_cyc, last_xfer_len;
  bit  gaps_on = 0;
  int  ready_mode = 0;

  task automatic clear_log();
    gnt_hist.delete();
    gnt_cyc.delete();
    for (int i = 0; i < N; i++) beats[i] = 0;
    abort_cnt = 0;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 0;
    return (m_st == M_IDLE);
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit has, gate;
      has  = head[i] < tail[i];
      gate = !gaps_on || gap[i] >= 2 || $urandom_range(0, 2) != 0;
      req_valid[i] = has && gate;
      req_data[i*DW +: DW] = has ? mem_d[i][head[i]] : 32'h0;
      req_last[i] = has && mem_l[i][head[i]];
      gap[i] = (has && !gate) ? gap[i] + 1 : 0;
    end
    case (ready_mode)
      1:       wifi_ready = (m_st == M_PKT) && (m_xfer % 2 == 1);
      2:       wifi_ready = ($urandom_range(0, 3) != 0);
      default: wifi_ready = 1'b1;
    endcase
  endtask

  task automatic sample_and_model();
    case (m_st)
      M_IDLE: begin
        check("idle_valid", wifi_valid, 0);
        check("idle_ready", req_ready, 0);
        check("idle_busy", busy, 0);
      end
      M_PKT: begin
        check("pkt_busy", busy, 1);
        check("pkt_src", wifi_src, m_src);
        check("pkt_valid", wifi_valid, req_valid[m_src]);
        check("pkt_ready", req_ready, wifi_ready ? (64'd1 << m_src) : 64'd0);
        check("pkt_abort", wifi_abort, 0);
        if (req_valid[m_src]) begin
          check("pkt_data", wifi_data, mem_d[m_src][head[m_src]]);
          check("pkt_last", wifi_last, mem_l[m_src][head[m_src]]);
        end
      end
      default: begin
        check("abt_beat", {wifi_valid, wifi_last, wifi_abort}, 3'b111);
        check("abt_data", wifi_data, 0);
        check("abt_ready", req_ready, 0);
        check("abt_busy", busy, 1);
      end
    endcase
    check("err_flag", err_timeout, m_err);

    case (m_st)
      M_IDLE: begin
        if (en && |req_valid) begin
          m_src = rr_pick();
          m_st = M_PKT;
          m_stall = 0;
          m_xfer = 0;
          gnt_hist.push_back(m_src);
          gnt_cyc.push_back(cyc + 1);
        end
      end
      M_PKT: begin
        m_xfer++;
        if (req_valid[m_src]) begin
          m_stall = 0;
          if (wifi_ready) begin
            bit lst;
            lst = mem_l[m_src][head[m_src]];
            head[m_src]++;
            beats[m_src]++;
            if (lst) begin
              m_st = M_IDLE;
              m_last = m_src;
              last_xfer_len = m_xfer;
            end
          end
        end else begin
          m_stall++;
          if (m_stall == T) m_st = M_ABT;
        end
      end
      default: begin
        if (wifi_ready) begin
          abort_cnt++;
          abort_cyc = cyc;
          m_err = 1;
          m_last = m_src;
          m_st = M_IDLE;
        end
      end
    endcase
    cyc++;
  endtask

  task automatic tick();
    drive();
    #1;
    sample_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, all_done(), 1);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_rst_outs"},
          {wifi_valid, wifi_data, wifi_last, wifi_abort, wifi_src, busy, err_timeout, req_ready}, 0);
    m_st = M_IDLE;
    m_last = N - 1;
    m_err = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      gap[i]  = 0;
    end
    req_valid = '0;
    req_last  = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int t_start, en_cyc, n;
    int exp_beats [N];

    apply_reset("t0");

    // Single source, 4-word packet.
    clear_log();
    en = 1'b1;
    push_pkt(0, 4, 32'hA0);
    t_start = cyc;
    run_until_done("t1", 50);
    check("t1_ngrants", gnt_hist.size(), 1);
    check("t1_src", gnt_hist[0], 0);
    check("t1_latency", gnt_cyc[0] - t_start, 1);
    check("t1_beats", beats[0], 4);
    check("t1_len", last_xfer_len, 4);
    tick();

    // Fairness with all sources busy.
    apply_reset("t2");
    clear_log();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) push_pkt(s, 2, 32'h100 * (s + 1) + 32'(p * 16));
    run_until_done("t2", 200);
    check("t2_ngrants", gnt_hist.size(), 6);
    for (int k = 0; k < 6 && k < gnt_hist.size(); k++) begin
      check("t2_order", gnt_hist[k], k % N);
      if (k > 0) check("t2_spacing", gnt_cyc[k] - gnt_cyc[k-1], 3);
    end

    // Wi-Fi backpressure, ready alternating starting low.
    clear_log();
    ready_mode = 1;
    push_pkt(2, 8, 32'hC0);
    run_until_done("t3", 100);
    ready_mode = 0;
    check("t3_beats", beats[2], 8);
    check("t3_len", last_xfer_len, 16);
    check("t3_err", err_timeout, 0);

    // Source stall abort.
    apply_reset("t4");
    clear_log();
    mem_d[1][0] = 32'hB0; mem_l[1][0] = 1'b0;
    mem_d[1][1] = 32'hB1; mem_l[1][1] = 1'b0;
    tail[1] = 2;
    push_pkt(2, 2, 32'hE0);
    run_until_done("t4", 100);
    check("t4_ngrants", gnt_hist.size(), 2);
    if (gnt_hist.size() == 2) begin
      check("t4_first", gnt_hist[0], 1);
      check("t4_next", gnt_hist[1], 2);
      check("t4_abort_time", abort_cyc - gnt_cyc[0], 10);
      check("t4_regrant", gnt_cyc[1] - abort_cyc, 2);
    end
    check("t4_aborts", abort_cnt, 1);
    check("t4_err", err_timeout, 1);

    // en gating mid-packet.
    clear_log();
    push_pkt(0, 4, 32'h50);
    push_pkt(1, 2, 32'h60);
    tick();
    tick();
    en = 1'b0;
    n = 0;
    while (beats[0] < 4 && n < 50) begin
      tick();
      n++;
    end
    check("t5_pkt_done", beats[0], 4);
    for (int k = 0; k < 6; k++) tick();
    check("t5_held", gnt_hist.size(), 1);
    check("t5_idle", busy, 0);
    en_cyc = cyc;
    en = 1'b1;
    run_until_done("t5", 50);
    check("t5_ngrants", gnt_hist.size(), 2);
    if (gnt_hist.size() == 2) begin
      check("t5_src", gnt_hist[1], 1);
      check("t5_resume", gnt_cyc[1] - en_cyc, 1);
    end

    // Reset on word 3 of 6.
    clear_log();
    push_pkt(0, 6, 32'h70);
    push_pkt(1, 2, 32'h90);
    n = 0;
    while (beats[0] < 2 && n < 50) begin
      tick();
      n++;
    end
    drive();
    #1;
    check("t6_word3", wifi_data, 32'h72);
    apply_reset("t6");
    clear_log();
    push_pkt(0, 2, 32'h80);
    push_pkt(1, 2, 32'h90);
    run_until_done("t6", 50);
    check("t6_ngrants", gnt_hist.size(), 2);
    if (gnt_hist.size() == 2) begin
      check("t6_first", gnt_hist[0], 0);
      check("t6_second", gnt_hist[1], 1);
    end

    // Randomized traffic, gaps, backpressure and en toggling.
    apply_reset("t7");
    clear_log();
    gaps_on = 1;
    ready_mode = 2;
    for (int s = 0; s < N; s++) exp_beats[s] = 0;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < N; s++) begin
        int len;
        len = $urandom_range(1, 5);
        exp_beats[s] += len;
        push_pkt(s, len, 32'h1000 * (s + 1) + 32'(r * 16));
      end
    end
    n = 0;
    while (!all_done() && n < 3000) begin
      en = ($urandom_range(0, 7) != 0);
      tick();
      n++;
    end
    en = 1'b1;
    check("t7_done", all_done(), 1);
    for (int s = 0; s < N; s++) check("t7_beats", beats[s], exp_beats[s]);
    check("t7_aborts", abort_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
